// File: rtl/load_size_seq.sv
// Load sequencer: issues a timed memory read, then returns the result sized and
// zero-extended according to the requested load width.
module load_size_seq #(
   parameter int unsigned MEM_LATENCY = 2  // cycles from mem_read to valid data, 1..15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  controleLS,
   input  logic [31:0] addr,
   input  logic [31:0] mem_data_in,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] ls_out
);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   localparam logic [1:0] SizeWord    = 2'b00;
   localparam logic [1:0] SizeByte    = 2'b01;
   localparam logic [1:0] SizeHalf    = 2'b10;
   localparam logic [1:0] SizeIllegal = 2'b11;

   // Last wait-count value; the capture happens on the edge that sees it.
   localparam logic [3:0] LastCnt = 4'(MEM_LATENCY - 1);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [1:0]  size_q;
   logic [31:0] mem_addr_q;
   logic        mem_read_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;
   logic [31:0] ls_out_q;
   logic [31:0] sized_data;

   // Select and zero-extend the memory data according to the latched size.
   always_comb begin
      sized_data = mem_data_in;
      unique case (size_q)
         SizeByte: sized_data = {24'b0, mem_data_in[7:0]};
         SizeHalf: sized_data = {16'b0, mem_data_in[15:0]};
         default:  sized_data = mem_data_in;
      endcase
   end

   // Sequencer FSM with all outputs registered; pulses default low each cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         size_q     <= SizeWord;
         mem_addr_q <= 32'd0;
         mem_read_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ls_out_q   <= 32'd0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (start && (controleLS != SizeIllegal)) begin
                  mem_addr_q <= addr;
                  size_q     <= controleLS;
                  cnt_q      <= 4'd0;
                  mem_read_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= StWait;
               end else begin
                  // Illegal size flags err and never touches memory.
                  err_q   <= start;
                  state_q <= StIdle;
               end
            end
            StWait: begin
               // start is deliberately ignored while a load is in flight.
               if (cnt_q == LastCnt) begin
                  ls_out_q   <= sized_data;
                  mem_read_q <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= StDone;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_read = mem_read_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign ls_out   = ls_out_q;

endmodule
